// File: rtl/picorv32_wb_bridge_pkg.sv
// Shared definitions for the picorv32 -> Wishbone bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the bridge FSM state encoding, the default error read data
// and the all-bytes select value used for reads.
package picorv32_wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } bridge_state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
    localparam logic [3:0]  SEL_ALL           = 4'hF;

    // Reads always fetch the full word; writes use the CPU byte strobes.
    function automatic logic [3:0] wb_sel_from_wstrb(input logic [3:0] wstrb);
        return (|wstrb) ? wstrb : SEL_ALL;
    endfunction

endpackage

// File: rtl/picorv32_wb_bridge_timeout.sv
// Transaction watchdog: counts cycles a Wishbone transaction stays open.
// Latency: o_expire is combinational from the registered count.
// Backpressure: none; counting is gated by i_enable, saturates at the last count.
//
// Ports:
//   i_clk, i_reset   - clock, synchronous active-high reset
//   i_clear          - zero the count (asserted on the edge entering REQ)
//   i_enable         - count this cycle (transaction open: REQ or WAIT)
//   o_expire         - count has reached TIMEOUT_CYCLES-1 while enabled
module wb_bridge_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Saturate at LAST so the counter can never wrap back to zero.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expire = i_enable && (r_count == LAST);

endmodule

// File: rtl/picorv32_wb_bridge.sv
// picorv32 native (valid/ready) to Wishbone pipelined master, one transaction at a time.
// Latency: >= 3 cycles valid-to-ready (request edge, termination edge, ready cycle).
// Backpressure: holds stb and all bus outputs stable while i_wb_stall; CPU waits on o_mem_ready.
//
// Ports:
//   i_clk, i_reset                      - clock, synchronous active-high reset
//   i_mem_*  / o_mem_ready, o_mem_rdata - picorv32 native memory interface
//   o_wb_* / i_wb_*                     - Wishbone pipelined master port
//   o_bus_fault                         - one-cycle pulse with a faulting o_mem_ready
//   o_fault_addr, o_fault_instr         - address / fetch flag of the most recent fault
//
// Build option WB_BRIDGE_TIMEOUT_EN: when defined, a transaction open for
// TIMEOUT_CYCLES cycles is aborted as a fault; otherwise the bridge waits
// indefinitely and faults come only from i_wb_err.
module picorv32_wb_bridge
    import picorv32_wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_valid,
    input  logic        i_mem_instr,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_wstrb,
    output logic        o_mem_ready,
    output logic [31:0] o_mem_rdata,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,
    output logic        o_bus_fault,
    output logic [31:0] o_fault_addr,
    output logic        o_fault_instr
);

    if ((TIMEOUT_CYCLES < 4) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("picorv32_wb_bridge: TIMEOUT_CYCLES out of range 4..65535");
    end

    bridge_state_t r_state;
    logic          r_instr;
    logic          w_open;
    logic          w_expire;

    assign w_open = (r_state == ST_REQ) || (r_state == ST_WAIT);

`ifdef WB_BRIDGE_TIMEOUT_EN
    logic w_to_clear;

    assign w_to_clear = (r_state == ST_IDLE) && i_mem_valid;

    wb_bridge_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_to_clear),
        .i_enable (w_open),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_instr       <= 1'b0;
            o_mem_ready   <= 1'b0;
            o_mem_rdata   <= '0;
            o_wb_addr     <= '0;
            o_wb_data     <= '0;
            o_wb_sel      <= '0;
            o_wb_we       <= 1'b0;
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
            o_bus_fault   <= 1'b0;
            o_fault_addr  <= '0;
            o_fault_instr <= 1'b0;
        end else begin
            // Both pulses are high only in the RESP cycle.
            o_mem_ready <= 1'b0;
            o_bus_fault <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_mem_valid) begin
                        o_wb_addr <= i_mem_addr;
                        o_wb_data <= i_mem_wdata;
                        o_wb_we   <= |i_mem_wstrb;
                        o_wb_sel  <= wb_sel_from_wstrb(i_mem_wstrb);
                        r_instr   <= i_mem_instr;
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end

                ST_REQ, ST_WAIT: begin
                    // Termination priority: err, then ack, then timeout.
                    if (i_wb_err || i_wb_ack || w_expire) begin
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_mem_ready <= 1'b1;
                        r_state     <= ST_RESP;
                        if (!i_wb_err && i_wb_ack) begin
                            o_mem_rdata <= o_wb_we ? 32'h0 : i_wb_data;
                        end else begin
                            o_mem_rdata   <= ERR_RDATA;
                            o_bus_fault   <= 1'b1;
                            o_fault_addr  <= o_wb_addr;
                            o_fault_instr <= r_instr;
                        end
                    end else if ((r_state == ST_REQ) && !i_wb_stall) begin
                        // Request accepted: one stb accept per cycle of cyc.
                        o_wb_stb <= 1'b0;
                        r_state  <= ST_WAIT;
                    end
                end

                // i_mem_valid may still be high here; it is deliberately ignored.
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
